// File: rtl/rr_burst_scheduler.sv
// Purpose : round-robin owner of one shared downstream burst port across NUM_REQ requesters.
// Latency : grant 1 cycle after the first req_valid; back-to-back bursts hand off with no idle cycle.
// Backpres: res_ready is passed to the owner's req_ready only; owner req_valid low stalls without losing the grant.
//
// Ports:
//   clk, rst_n          rising-edge clock, async active-low reset
//   req_valid[i]        requester i beat valid, held for the whole burst
//   req_len[i]          requester i burst length minus 1, sampled at grant
//   req_ready[i]        requester i beat accept (only the owner can see it high)
//   res_valid/res_ready downstream beat handshake
//   res_id              index of the current owner
//   res_last            current beat is the last of the burst
//   busy                a burst is in progress
module rr_burst_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int LEN_W   = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ-1:0][LEN_W-1:0]   req_len,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic                            res_valid,
   output logic [ID_W-1:0]                 res_id,
   output logic                            res_last,
   input  logic                            res_ready,
   output logic                            busy
);

   typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_e;

   state_e            state_q,    state_d;
   logic [ID_W-1:0]   owner_q,    owner_d;
   logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic [ID_W-1:0]   last_ptr_q, last_ptr_d;

   // Shared arbiter. In IDLE it rotates from last_ptr; during a burst it is
   // only consumed on the last beat, where the owner acts as the pointer and
   // is itself masked out so a different requester gets the handoff.
   logic [ID_W-1:0]    arb_ptr;
   logic [NUM_REQ-1:0] arb_mask;
   logic [ID_W-1:0]    arb_win;
   logic               arb_any;
   logic               beat_acc;

   always_comb begin
      int idx;
      idx      = 0;
      arb_ptr  = (state_q == BURST) ? owner_q : last_ptr_q;
      arb_mask = req_valid;
      if (state_q == BURST) begin
         arb_mask[owner_q] = 1'b0;
      end
      arb_any = 1'b0;
      arb_win = '0;
      // Walk from the farthest candidate to the nearest so the nearest
      // valid requester after the pointer is the one that sticks.
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = int'(arb_ptr) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (arb_mask[idx]) begin
            arb_any = 1'b1;
            arb_win = ID_W'(idx);
         end
      end
   end

   assign beat_acc = (state_q == BURST) && req_valid[owner_q] && res_ready;

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      beat_cnt_d = beat_cnt_q;
      last_ptr_d = last_ptr_q;
      req_ready  = '0;
      res_valid  = 1'b0;
      res_id     = '0;
      res_last   = 1'b0;
      busy       = 1'b0;
      case (state_q)
         IDLE: begin
            if (arb_any) begin
               owner_d    = arb_win;
               beat_cnt_d = req_len[arb_win];
               state_d    = BURST;
            end
         end
         BURST: begin
            busy               = 1'b1;
            res_id             = owner_q;
            res_valid          = req_valid[owner_q];
            res_last           = (beat_cnt_q == '0);
            req_ready[owner_q] = res_ready;
            if (beat_acc) begin
               if (beat_cnt_q != '0) begin
                  beat_cnt_d = beat_cnt_q - 1'b1;
               end else begin
                  last_ptr_d = owner_q;
                  if (arb_any) begin
                     owner_d    = arb_win;
                     beat_cnt_d = req_len[arb_win];
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         beat_cnt_q <= '0;
         last_ptr_q <= ID_W'(NUM_REQ - 1);
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         beat_cnt_q <= beat_cnt_d;
         last_ptr_q <= last_ptr_d;
      end
   end

   a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
   a_valid_in_burst: assert property (@(posedge clk) disable iff (!rst_n) res_valid |-> (state_q == BURST));

endmodule
